// File: rtl/rvfi_imem_learn_check.sv
// ---------------------------------------------------------------------------
// rvfi_imem_learn_check
//
// Instruction-memory consistency checker that sits beside a core's RVFI port.
// Each of NSLOTS slots watches one halfword address. The first retired
// instruction that covers that halfword teaches the slot its contents. Every
// later retirement covering the same halfword must report identical bits.
// The first mismatch seen is captured on registered outputs and held until
// reset.
//
// Optional feature (macro RISCV_FORMAL_IMEM_STORE_INVAL_EN):
//   When defined, a retired store that writes either byte of a tracked
//   halfword makes that slot forget its learned contents, so self-modifying
//   code is accepted. When undefined, the store inputs are unused and a
//   changed instruction is always reported as a mismatch.
//
// Parameters:
//   XLEN   - address/data width
//   NRET   - retire channels per cycle
//   NSLOTS - number of tracked halfword addresses (1..16)
//
// Ports:
//   clk            - clock
//   reset          - asynchronous active-high reset
//   trk_addr       - per-slot tracked halfword address (bit 0 ignored), stable
//   rvfi_valid     - retire valid per channel
//   rvfi_insn      - retired instruction per channel
//   rvfi_pc_rdata  - instruction PC per channel
//   rvfi_mem_addr  - memory byte address per channel
//   rvfi_mem_wmask - store byte mask per channel
//   slot_valid     - slot holds learned data
//   check_cnt      - number of comparisons performed (saturating)
//   err            - sticky mismatch flag
//   err_slot       - slot of the first mismatch
//   err_exp        - learned halfword at the first mismatch
//   err_got        - offending halfword at the first mismatch
// ---------------------------------------------------------------------------
module rvfi_imem_learn_check #(
   parameter int XLEN   = 32,
   parameter int NRET   = 1,
   parameter int NSLOTS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NSLOTS*XLEN-1:0] trk_addr,
   input  logic [NRET-1:0]        rvfi_valid,
   input  logic [NRET*32-1:0]     rvfi_insn,
   input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
   input  logic [NRET*XLEN-1:0]   rvfi_mem_addr,
   input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
   output logic [NSLOTS-1:0]      slot_valid,
   output logic [31:0]            check_cnt,
   output logic                   err,
   output logic [3:0]             err_slot,
   output logic [15:0]            err_exp,
   output logic [15:0]            err_got
);

   // Clearing bit 0 turns any byte address into the address of its halfword.
   localparam logic [XLEN-1:0] HALF_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   logic [15:0]       slotData [NSLOTS];
   logic [15:0]       nextData [NSLOTS];
   logic [NSLOTS-1:0] nextValid;
   logic              nextErr;
   logic [3:0]        nextErrSlot;
   logic [15:0]       nextErrExp;
   logic [15:0]       nextErrGot;
   logic [31:0]       checksThisCycle;
   logic [32:0]       cntSum;
   logic [31:0]       nextCnt;
   logic [XLEN-1:0]   pc;
   logic [31:0]       insn;
   logic [XLEN-1:0]   halfAddr;
   logic [15:0]       halfData;
   logic [XLEN-1:0]   byteAddr;

`ifndef RISCV_FORMAL_IMEM_STORE_INVAL_EN
   // Without store invalidation the memory-write side of RVFI has no effect;
   // fold it into a sink so it is visibly consumed.
   logic unusedStoreInputs;
   assign unusedStoreInputs = ^{rvfi_mem_addr, rvfi_mem_wmask};
`endif

   // Walk the retire channels in index order as one combinational chain.
   // Each channel sees the slot state left behind by the channels before it,
   // so a halfword learned by channel 0 is already checked by channel 1 in
   // the same cycle. Within a channel the low halfword is handled before the
   // high one and slots are scanned from 0 upward; the first mismatch reached
   // in that order is the one captured, because nextErr blocks later ones.
   // Store invalidation for a channel runs after that channel's own fetch
   // checks and before the next channel starts.
   always_comb begin
      nextValid       = slot_valid;
      nextData        = slotData;
      nextErr         = err;
      nextErrSlot     = err_slot;
      nextErrExp      = err_exp;
      nextErrGot      = err_got;
      checksThisCycle = '0;
      pc              = '0;
      insn            = '0;
      halfAddr        = '0;
      halfData        = '0;
      byteAddr        = '0;
      for (int c = 0; c < NRET; c++) begin
         if (rvfi_valid[c]) begin
            pc   = rvfi_pc_rdata[c*XLEN +: XLEN];
            insn = rvfi_insn[c*32 +: 32];
            for (int h = 0; h < 2; h++) begin
               if (h == 0 || insn[1:0] == 2'b11) begin
                  halfAddr = (h == 0) ? pc : pc + XLEN'(2);
                  halfData = (h == 0) ? insn[15:0] : insn[31:16];
                  for (int k = 0; k < NSLOTS; k++) begin
                     if ((halfAddr & HALF_MASK) == (trk_addr[k*XLEN +: XLEN] & HALF_MASK)) begin
                        if (!nextValid[k]) begin
                           nextValid[k] = 1'b1;
                           nextData[k]  = halfData;
                        end else begin
                           checksThisCycle = checksThisCycle + 32'd1;
                           if (nextData[k] != halfData && !nextErr) begin
                              nextErr     = 1'b1;
                              nextErrSlot = 4'(k);
                              nextErrExp  = nextData[k];
                              nextErrGot  = halfData;
                           end
                        end
                     end
                  end
               end
            end
`ifdef RISCV_FORMAL_IMEM_STORE_INVAL_EN
            // A written byte hits a slot when it lands on either byte of the
            // tracked halfword, which is the same as matching with bit 0
            // cleared.
            for (int b = 0; b < XLEN/8; b++) begin
               if (rvfi_mem_wmask[c*(XLEN/8) + b]) begin
                  byteAddr = rvfi_mem_addr[c*XLEN +: XLEN] + XLEN'(b);
                  for (int k = 0; k < NSLOTS; k++) begin
                     if ((byteAddr & HALF_MASK) == (trk_addr[k*XLEN +: XLEN] & HALF_MASK)) begin
                        nextValid[k] = 1'b0;
                     end
                  end
               end
            end
`endif
         end
      end
      cntSum  = {1'b0, check_cnt} + {1'b0, checksThisCycle};
      nextCnt = cntSum[32] ? '1 : cntSum[31:0];
   end

   // Register everything computed by the chain. Reset wipes all learned
   // contents and the error capture, so the next covering fetch relearns.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_valid <= '0;
         check_cnt  <= '0;
         err        <= 1'b0;
         err_slot   <= '0;
         err_exp    <= '0;
         err_got    <= '0;
         for (int k = 0; k < NSLOTS; k++) begin
            slotData[k] <= '0;
         end
      end else begin
         slot_valid <= nextValid;
         check_cnt  <= nextCnt;
         err        <= nextErr;
         err_slot   <= nextErrSlot;
         err_exp    <= nextErrExp;
         err_got    <= nextErrGot;
         for (int k = 0; k < NSLOTS; k++) begin
            slotData[k] <= nextData[k];
         end
      end
   end

endmodule

// File: tb/tb_rvfi_imem_learn_check.sv
// ---------------------------------------------------------------------------
// tb_rvfi_imem_learn_check
//
// Self-checking bench for rvfi_imem_learn_check with two retire channels and
// four slots. A table of directed vectors covers the worked scenarios
// (learn/check, high-halfword learning, address wrap, same-cycle channel
// ordering, store invalidation), a hand-written sequence covers reset in the
// middle of traffic, and a randomized phase is compared against a halfword
// level reference model. Honors RISCV_FORMAL_IMEM_STORE_INVAL_EN.
// ---------------------------------------------------------------------------
module tb_rvfi_imem_learn_check;

   localparam int XLEN   = 32;
   localparam int NRET   = 2;
   localparam int NSLOTS = 4;

`ifdef RISCV_FORMAL_IMEM_STORE_INVAL_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif

   localparam logic [127:0] TRK1 = {32'h400, 32'h300, 32'h000, 32'h100};
   localparam logic [127:0] TRK2 = {32'h600, 32'h500, 32'h400, 32'h102};
   localparam logic [127:0] TRK3 = {32'h600, 32'h500, 32'h400, 32'h200};

   logic                   clk;
   logic                   reset;
   logic [NSLOTS*XLEN-1:0] trk_addr;
   logic [NRET-1:0]        rvfi_valid;
   logic [NRET*32-1:0]     rvfi_insn;
   logic [NRET*XLEN-1:0]   rvfi_pc_rdata;
   logic [NRET*XLEN-1:0]   rvfi_mem_addr;
   logic [NRET*XLEN/8-1:0] rvfi_mem_wmask;
   logic [NSLOTS-1:0]      slot_valid;
   logic [31:0]            check_cnt;
   logic                   err;
   logic [3:0]             err_slot;
   logic [15:0]            err_exp;
   logic [15:0]            err_got;

   int checks = 0;
   int errors = 0;

   // Reference model state: what each slot knows, plus the error capture.
   bit          mValid [NSLOTS];
   logic [15:0] mData  [NSLOTS];
   longint      mCnt;
   bit          mErr;
   logic [3:0]  mSlot;
   logic [15:0] mExp;
   logic [15:0] mGot;

   typedef struct {
      bit           doReset;
      logic [127:0] trk;
      logic [1:0]   v;
      logic [31:0]  i0;
      logic [31:0]  p0;
      logic [31:0]  i1;
      logic [31:0]  p1;
      logic [31:0]  m0;
      logic [3:0]   w0;
      logic [3:0]   eV;
      logic [31:0]  eC;
      logic         eE;
      logic [3:0]   eS;
      logic [15:0]  eX;
      logic [15:0]  eG;
   } vecT;

   vecT vecs [13];

   rvfi_imem_learn_check #(
      .XLEN   (XLEN),
      .NRET   (NRET),
      .NSLOTS (NSLOTS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .trk_addr       (trk_addr),
      .rvfi_valid     (rvfi_valid),
      .rvfi_insn      (rvfi_insn),
      .rvfi_pc_rdata  (rvfi_pc_rdata),
      .rvfi_mem_addr  (rvfi_mem_addr),
      .rvfi_mem_wmask (rvfi_mem_wmask),
      .slot_valid     (slot_valid),
      .check_cnt      (check_cnt),
      .err            (err),
      .err_slot       (err_slot),
      .err_exp        (err_exp),
      .err_got        (err_got)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Forget everything the model has learned, as the DUT does on reset.
   task automatic modelReset();
      for (int k = 0; k < NSLOTS; k++) begin
         mValid[k] = 1'b0;
         mData[k]  = '0;
      end
      mCnt  = 0;
      mErr  = 1'b0;
      mSlot = '0;
      mExp  = '0;
      mGot  = '0;
   endtask

   // Advance the model by one retirement cycle using the currently driven
   // inputs. Each channel is turned into a list of (halfword index, bits)
   // fetches; a slot matches when its halfword index (address >> 1) agrees.
   task automatic modelStep();
      longint n;
      n = 0;
      for (int c = 0; c < NRET; c++) begin
         if (rvfi_valid[c]) begin
            logic [31:0] pcv;
            logic [31:0] iv;
            logic [31:0] addrs [$];
            logic [15:0] halves [$];
            pcv = rvfi_pc_rdata[c*32 +: 32];
            iv  = rvfi_insn[c*32 +: 32];
            addrs.push_back(pcv);
            halves.push_back(iv[15:0]);
            if (iv[1:0] == 2'b11) begin
               addrs.push_back(pcv + 32'd2);
               halves.push_back(iv[31:16]);
            end
            foreach (addrs[i]) begin
               for (int k = 0; k < NSLOTS; k++) begin
                  if ((addrs[i] >> 1) == (trk_addr[k*32 +: 32] >> 1)) begin
                     if (!mValid[k]) begin
                        mValid[k] = 1'b1;
                        mData[k]  = halves[i];
                     end else begin
                        n++;
                        if (mData[k] != halves[i] && !mErr) begin
                           mErr  = 1'b1;
                           mSlot = 4'(k);
                           mExp  = mData[k];
                           mGot  = halves[i];
                        end
                     end
                  end
               end
            end
            if (INV) begin
               for (int b = 0; b < 4; b++) begin
                  if (rvfi_mem_wmask[c*4 + b]) begin
                     logic [31:0] byteA;
                     byteA = rvfi_mem_addr[c*32 +: 32] + 32'(b);
                     for (int k = 0; k < NSLOTS; k++) begin
                        if ((byteA >> 1) == (trk_addr[k*32 +: 32] >> 1)) begin
                           mValid[k] = 1'b0;
                        end
                     end
                  end
               end
            end
         end
      end
      mCnt = mCnt + n;
      if (mCnt > 64'hFFFF_FFFF) begin
         mCnt = 64'hFFFF_FFFF;
      end
   endtask

   // Pulse reset with the retire interface idle and clear the model.
   task automatic resetDut();
      @(negedge clk);
      reset          = 1'b1;
      rvfi_valid     = '0;
      rvfi_mem_wmask = '0;
      modelReset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Drive one retirement cycle, let the DUT and model consume it, and leave
   // time set to just after the sampling edge.
   task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                                input logic [31:0] i1, input logic [31:0] p1,
                                input logic [31:0] m0, input logic [3:0] w0,
                                input logic [31:0] m1, input logic [3:0] w1);
      @(negedge clk);
      rvfi_valid     = v;
      rvfi_insn      = {i1, i0};
      rvfi_pc_rdata  = {p1, p0};
      rvfi_mem_addr  = {m1, m0};
      rvfi_mem_wmask = {w1, w0};
      @(posedge clk);
      modelStep();
      #1;
   endtask

   // Compare every output against the supplied expectations.
   task automatic checkOutput(input string tag, input logic [3:0] eV, input logic [31:0] eC,
                              input logic eE, input logic [3:0] eS,
                              input logic [15:0] eX, input logic [15:0] eG);
      checks += 6;
      if (slot_valid !== eV) begin
         errors++;
         $display("[TB] FAIL %s slot_valid got %b want %b", tag, slot_valid, eV);
      end
      if (check_cnt !== eC) begin
         errors++;
         $display("[TB] FAIL %s check_cnt got %0d want %0d", tag, check_cnt, eC);
      end
      if (err !== eE) begin
         errors++;
         $display("[TB] FAIL %s err got %b want %b", tag, err, eE);
      end
      if (err_slot !== eS) begin
         errors++;
         $display("[TB] FAIL %s err_slot got %0d want %0d", tag, err_slot, eS);
      end
      if (err_exp !== eX) begin
         errors++;
         $display("[TB] FAIL %s err_exp got %h want %h", tag, err_exp, eX);
      end
      if (err_got !== eG) begin
         errors++;
         $display("[TB] FAIL %s err_got got %h want %h", tag, err_got, eG);
      end
   endtask

   task automatic checkModel(input string tag);
      logic [3:0] mv;
      for (int k = 0; k < NSLOTS; k++) begin
         mv[k] = mValid[k];
      end
      checkOutput(tag, mv, mCnt[31:0], mErr, mSlot, mExp, mGot);
   endtask

   // Deterministic "true" memory contents for the random phase.
   function automatic logic [15:0] stableAt(input logic [31:0] a, input logic [15:0] seed);
      logic [31:0] h;
      h = (a >> 1) * 32'h9E37_79B9;
      return h[31:16] ^ seed;
   endfunction

   initial begin
      logic [31:0] pool [8];
      logic [15:0] seed;

      reset          = 1'b1;
      trk_addr       = TRK1;
      rvfi_valid     = '0;
      rvfi_insn      = '0;
      rvfi_pc_rdata  = '0;
      rvfi_mem_addr  = '0;
      rvfi_mem_wmask = '0;
      modelReset();

      vecs[0]  = '{1'b1, TRK1, 2'b01, 32'h00A00093, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0001, 32'd0, 1'b0, 4'd0, 16'h0, 16'h0};
      vecs[1]  = '{1'b0, TRK1, 2'b01, 32'h00A00093, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0001, 32'd1, 1'b0, 4'd0, 16'h0, 16'h0};
      vecs[2]  = '{1'b0, TRK1, 2'b01, 32'h00004501, 32'h300, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0101, 32'd1, 1'b0, 4'd0, 16'h0, 16'h0};
      vecs[3]  = '{1'b0, TRK1, 2'b01, 32'h00112023, 32'h500, 32'h0, 32'h0, 32'h300, 4'b0010,
                   INV ? 4'b0001 : 4'b0101, 32'd1, 1'b0, 4'd0, 16'h0, 16'h0};
      vecs[4]  = '{1'b0, TRK1, 2'b01, 32'h00004505, 32'h300, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0101, INV ? 32'd1 : 32'd2, !INV, INV ? 4'd0 : 4'd2,
                   INV ? 16'h0 : 16'h4501, INV ? 16'h0 : 16'h4505};
      vecs[5]  = '{1'b0, TRK1, 2'b01, 32'h12345013, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0111, INV ? 32'd1 : 32'd2, !INV, INV ? 4'd0 : 4'd2,
                   INV ? 16'h0 : 16'h4501, INV ? 16'h0 : 16'h4505};
      vecs[6]  = '{1'b0, TRK1, 2'b01, 32'h00001235, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0111, INV ? 32'd2 : 32'd3, 1'b1, INV ? 4'd1 : 4'd2,
                   INV ? 16'h1234 : 16'h4501, INV ? 16'h1235 : 16'h4505};
      vecs[7]  = '{1'b1, TRK2, 2'b01, 32'h00A00093, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0001, 32'd0, 1'b0, 4'd0, 16'h0, 16'h0};
      vecs[8]  = '{1'b0, TRK2, 2'b01, 32'h00B00093, 32'h100, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0001, 32'd1, 1'b1, 4'd0, 16'h00A0, 16'h00B0};
      vecs[9]  = '{1'b1, TRK3, 2'b11, 32'h00000001, 32'h200, 32'h00000005, 32'h200, 32'h0, 4'h0,
                   4'b0001, 32'd1, 1'b1, 4'd0, 16'h0001, 16'h0005};
      vecs[10] = '{1'b0, TRK3, 2'b11, 32'h00000009, 32'h200, 32'h0000000D, 32'h200, 32'h0, 4'h0,
                   4'b0001, 32'd3, 1'b1, 4'd0, 16'h0001, 16'h0005};
      vecs[11] = '{1'b1, TRK3, 2'b01, 32'h00000001, 32'h200, 32'h0, 32'h0, 32'h0, 4'h0,
                   4'b0001, 32'd0, 1'b0, 4'd0, 16'h0, 16'h0};
      vecs[12] = '{1'b0, TRK3, 2'b11, 32'h00000009, 32'h200, 32'h0000000D, 32'h200, 32'h0, 4'h0,
                   4'b0001, 32'd2, 1'b1, 4'd0, 16'h0001, 16'h0009};

      @(negedge clk);
      #1;
      checkOutput("initReset", 4'b0, 32'd0, 1'b0, 4'd0, 16'h0, 16'h0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].doReset) begin
            trk_addr = vecs[i].trk;
            resetDut();
         end
         applyStimulus(vecs[i].v, vecs[i].i0, vecs[i].p0, vecs[i].i1, vecs[i].p1,
                       vecs[i].m0, vecs[i].w0, 32'h0, 4'h0);
         checkOutput($sformatf("row%0d", i), vecs[i].eV, vecs[i].eC, vecs[i].eE,
                     vecs[i].eS, vecs[i].eX, vecs[i].eG);
      end

      // Reset in the middle of traffic, with a retirement presented while
      // reset is high; everything clears at once and stays clear.
      @(negedge clk);
      reset          = 1'b1;
      rvfi_valid     = 2'b01;
      rvfi_insn      = {32'h0, 32'h00000011};
      rvfi_pc_rdata  = {32'h0, 32'h200};
      #1;
      checkOutput("asyncReset", 4'b0, 32'd0, 1'b0, 4'd0, 16'h0, 16'h0);
      @(posedge clk);
      #1;
      checkOutput("resetHeld", 4'b0, 32'd0, 1'b0, 4'd0, 16'h0, 16'h0);
      @(negedge clk);
      reset      = 1'b0;
      rvfi_valid = '0;
      modelReset();
      applyStimulus(2'b01, 32'h00000015, 32'h200, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0);
      checkOutput("relearn", 4'b0001, 32'd0, 1'b0, 4'd0, 16'h0, 16'h0);
      applyStimulus(2'b01, 32'h00000019, 32'h200, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0);
      checkOutput("freshErr", 4'b0001, 32'd1, 1'b1, 4'd0, 16'h0015, 16'h0019);

      // Randomized traffic over a small address pool (including the wrap
      // point) compared cycle by cycle against the model.
      pool = '{32'h1000, 32'h1002, 32'h1004, 32'h1006, 32'h1008, 32'hFFFFFFFE, 32'h0, 32'h2};
      for (int ep = 0; ep < 6; ep++) begin
         seed = 16'($urandom);
         for (int k = 0; k < NSLOTS; k++) begin
            trk_addr[k*32 +: 32] = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 1));
         end
         resetDut();
         for (int cyc = 0; cyc < 60; cyc++) begin
            logic [1:0]  v;
            logic [31:0] ins [2];
            logic [31:0] pcs [2];
            logic [31:0] mas [2];
            logic [3:0]  wms [2];
            for (int c = 0; c < 2; c++) begin
               logic [15:0] lo;
               logic [15:0] hi;
               v[c]   = ($urandom_range(0, 9) < 7);
               pcs[c] = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 1));
               lo     = ($urandom_range(0, 19) == 0) ? 16'($urandom) : stableAt(pcs[c], seed);
               hi     = ($urandom_range(0, 19) == 0) ? 16'($urandom) : stableAt(pcs[c] + 32'd2, seed);
               ins[c] = {hi, lo};
               mas[c] = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
               wms[c] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            applyStimulus(v, ins[0], pcs[0], ins[1], pcs[1], mas[0], wms[0], mas[1], wms[1]);
            checkModel($sformatf("rand%0d_%0d", ep, cyc));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvfi_imem_learn_check.md
Name: rvfi_imem_learn_check

Overview:
- Multi-slot instruction-memory consistency checker for the RVFI formal/sim harness.
- Each of NSLOTS slots tracks one halfword address. The slot learns that halfword's contents on the first retired instruction covering it. Every later retirement covering that address must report identical bits.
- Optionally forgets learned contents when a retired store writes the tracked bytes, so self-modifying code is accepted.
- Sits beside the core's RVFI port. Reports the first mismatch on registered outputs.

Parameters:
- XLEN, 32, address/data width.
- NRET, 1, retire channels per cycle.
- NSLOTS, 4, tracked halfword addresses (1..16).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- trk_addr  in  NSLOTS*XLEN  slot k halfword address; bit 0 ignored; hold stable (formal: $anyconst).
- rvfi_valid  in  NRET  retire valid per channel.
- rvfi_insn  in  NRET*32  retired instruction.
- rvfi_pc_rdata  in  NRET*XLEN  instruction PC.
- rvfi_mem_addr  in  NRET*XLEN  memory byte address.
- rvfi_mem_wmask  in  NRET*XLEN/8  store byte mask.
- slot_valid  out  NSLOTS  slot holds learned data.
- check_cnt  out  32  comparisons performed, saturating at 0xFFFFFFFF.
- err  out  1  sticky mismatch flag.
- err_slot  out  4  slot of first mismatch.
- err_exp  out  16  learned halfword at first mismatch.
- err_got  out  16  offending halfword.

Behaviour:
- Reset is asynchronous. All outputs, slot data and slot_valid clear to 0.
- All state updates on the posedge clk that samples rvfi_valid. Results are visible the following cycle (latency 1).
- Halfword coverage per valid channel c, with pc = rvfi_pc_rdata[c]:
  - lo = insn[15:0] at pc.
  - If insn[1:0]==2'b11, also hi = insn[31:16] at pc+2. Wrap mod 2^XLEN, so pc=0xFFFFFFFE covers address 0x00000000.
  - A 16-bit insn covers only pc.
- Slot k matches a covered halfword when (address & ~1) == (trk_addr[k] & ~1). pc is compared with bit 0 cleared.
- Per matching halfword:
  - Slot invalid -> store the halfword, set slot_valid[k]. No check, no count.
  - Slot valid -> check_cnt++. If the halfword differs from stored data: mismatch.
- Channels are processed sequentially in index order within one cycle, 0 first, via a combinational chain over NRET:
  - A slot learned by channel i is checked by channel j>i in the same cycle.
  - Store invalidation by channel i (feature on) takes effect after channel i's own checks and before channel i+1.
- Mismatch handling:
  - If err==0, set err and capture err_slot, err_exp, err_got.
  - Later mismatches increment nothing extra and do not overwrite the capture. err is cleared only by reset.
- Multiple mismatches in one cycle: lowest channel wins, then lo before hi, then lowest slot.
- A slot's stored data never changes while valid, except via invalidation.
- check_cnt increments by the total number of checks in the cycle (up to 2*NRET*NSLOTS) and saturates.
- reset asserted mid-stream discards all learned data. rvfi_valid during reset is ignored.
- Channels with rvfi_valid=0 are ignored entirely, including their wmask.

Optional Feature:
- Macro RISCV_FORMAL_IMEM_STORE_INVAL_EN.
- Defined:
  - Each valid channel with wmask bit b set writes byte address mem_addr+b (mod 2^XLEN).
  - If any such byte equals (trk_addr[k]&~1) or (trk_addr[k]&~1)+1, slot_valid[k] clears. The next covering fetch relearns.
  - Does not clear err or its capture.
- Undefined: wmask/mem_addr are unused. Stores never affect slots, and a changed instruction is a mismatch.

Test Plan:
- trk_addr[0]=0x100. Retire insn 0x00A00093 at pc 0x100, then again. -> slot_valid[0]=1; check_cnt=1; err=0.
- trk_addr[0]=0x102. Retire 0x00A00093 at pc 0x100, then 0x00B00093 at 0x100. -> hi halfword 0x00A0 learned, then checked against 0x00B0 -> err=1, err_slot=0, err_exp=0x00A0, err_got=0x00B0.
- trk_addr[1]=0x0. Retire 32-bit 0x12345013 at pc 0xFFFFFFFE, then 16-bit 0x1235 at pc 0x0. -> slot 1 learns 0x1234 via wrap; mismatch err_exp=0x1234, err_got=0x1235.
- NRET=2, trk_addr[0]=0x200. Same cycle: ch0 retires 0x0001 at 0x200, ch1 retires 0x0005 at 0x200. -> ch0 learns, ch1 mismatches in that cycle; err_got=0x0005.
- Feature on, trk_addr[2]=0x300. Learn 0x4501 at 0x300. Store mem_addr=0x300, wmask=4'b0010. Retire 0x4505 at 0x300. -> slot invalidated then relearned; err=0. Feature off: err=1.
- After err=1, assert reset for 1 cycle mid-stream. -> all outputs 0; next fetch relearns; a second mismatch captures fresh values.
